core_ma_lsu_load_merge: RTL and testbench

Read-response receiver for the memory-access stage load/store unit. Tracks read commands accepted on the LSU's Avalon-MM master (avl_m0), collects the one or two in-order read-data beats of a load, and merges them. A misaligned load that crosses a word boundary is reassembled from both words, then truncated and sign- or zero-extended to a 32-bit load result for the writeback path.

---
 rtl/core_define.sv | 38 +++
 rtl/core_ma_lsu_load_extend.sv | 33 +++
 rtl/core_ma_lsu_load_merge.sv | 133 +++++++++++++
 tb/tb_core_ma_lsu_load_merge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_define.sv
// Shared definitions for the LSU load path: op-type and length codes,
// the load-merge state encoding, and small decode helpers.
`ifndef CORE_DEFINE_SV
`define CORE_DEFINE_SV

`define MEM_OP_TYPE_UNSIGNED 3'b100
`define MEM_LEN_BYTE         3'd1
`define MEM_LEN_HALF         3'd2
`define MEM_LEN_WORD         3'd4

package core_define;

  localparam logic [2:0] MEM_OP_TYPE_UNSIGNED = `MEM_OP_TYPE_UNSIGNED;
  localparam logic [2:0] MEM_LEN_BYTE         = `MEM_LEN_BYTE;
  localparam logic [2:0] MEM_LEN_HALF         = `MEM_LEN_HALF;
  localparam logic [2:0] MEM_LEN_WORD         = `MEM_LEN_WORD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2,
    RESP  = 2'd3
  } load_state_e;

  // Any length code other than byte or half is a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    if (len == MEM_LEN_BYTE || len == MEM_LEN_HALF) return len;
    return MEM_LEN_WORD;
  endfunction

  // A load needs a second word when its bytes run past the end of the first.
  function automatic logic is_two_beat(input logic [1:0] off, input logic [2:0] len);
    return ({2'b00, off} + {1'b0, len}) > 4'd4;
  endfunction

endpackage

`endif

// File: rtl/core_ma_lsu_load_extend.sv
// Combinational merge of one or two read words into the addressed bytes,
// followed by truncation and sign/zero extension to 32 bits.
module core_ma_lsu_load_extend
  import core_define::*;
(
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  len_i,
  input  logic [2:0]  op_type_i,
  output logic [31:0] data_o
);

  logic [31:0] merged;
  logic        is_unsigned;

  assign is_unsigned = (op_type_i == MEM_OP_TYPE_UNSIGNED);

  // Shift the two-word window down by the byte offset, then extend by length.
  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    merged = 32'({word1_i, word0_i} >> {off_i, 3'b000});
    data_o = merged;
    case (len_i)
      MEM_LEN_BYTE: data_o = is_unsigned ? {24'b0, merged[7:0]}
                                         : {{24{merged[7]}}, merged[7:0]};
      MEM_LEN_HALF: data_o = is_unsigned ? {16'b0, merged[15:0]}
                                         : {{16{merged[15]}}, merged[15:0]};
      default:      data_o = merged;
    endcase
  end

endmodule

// File: rtl/core_ma_lsu_load_merge.sv
// Read-response receiver for LSU loads: tracks the accepted read command,
// collects one or two in-order beats and produces the extended load result.
// Build option: CORE_LSU_LOAD_DATA_REG_EN registers the result and adds a RESP
// state; without it the result is presented combinationally with the final beat.
module core_ma_lsu_load_merge
  import core_define::*;
(
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic [2:0]  mem_op_type,
  input  logic [2:0]  mem_op_data_len,
  input  logic        avl_m0_read,
  input  logic        avl_m0_request_ready,
  input  logic [31:0] avl_m0_read_data,
  input  logic        avl_m0_read_data_valid,
  output logic        mem_load_busy,
  output logic [31:0] mem_load_data,
  output logic        mem_load_data_valid
);

  load_state_e state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  type_q, type_d;
  logic        two_beat_q, two_beat_d;
  logic [31:0] buf0_q, buf0_d;

  logic        accept;
  logic        finish;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [31:0] ext_data;

  // Only the byte offset within the word matters here.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:2];

  assign accept = avl_m0_read && avl_m0_request_ready;

  // Next-state and capture logic; accepts outside IDLE and beats in IDLE are ignored.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    len_d      = len_q;
    type_d     = type_q;
    two_beat_d = two_beat_q;
    buf0_d     = buf0_q;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && mem_read) begin
          off_d      = mem_addr[1:0];
          len_d      = norm_len(mem_op_data_len);
          type_d     = mem_op_type;
          two_beat_d = is_two_beat(mem_addr[1:0], norm_len(mem_op_data_len));
          state_d    = WAIT0;
        end
      end
      WAIT0: begin
        if (avl_m0_read_data_valid) begin
          buf0_d = avl_m0_read_data;
          if (two_beat_q) state_d = WAIT1;
          else            finish  = 1'b1;
        end
      end
      WAIT1: begin
        if (avl_m0_read_data_valid) finish = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
`ifdef CORE_LSU_LOAD_DATA_REG_EN
      state_d = RESP;
`else
      state_d = IDLE;
`endif
    end
  end

  // State and capture registers; reset discards any load in progress.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= IDLE;
      off_q      <= '0;
      len_q      <= '0;
      type_q     <= '0;
      two_beat_q <= 1'b0;
      buf0_q     <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      len_q      <= len_d;
      type_q     <= type_d;
      two_beat_q <= two_beat_d;
      buf0_q     <= buf0_d;
    end
  end

  // The live beat is word0 for the first beat and word1 for the second.
  assign word0 = (state_q == WAIT1) ? buf0_q : avl_m0_read_data;
  assign word1 = (state_q == WAIT1) ? avl_m0_read_data : 32'b0;

  core_ma_lsu_load_extend u_extend (
    .word0_i   (word0),
    .word1_i   (word1),
    .off_i     (off_q),
    .len_i     (len_q),
    .op_type_i (type_q),
    .data_o    (ext_data)
  );

  assign mem_load_busy = (state_q != IDLE);

`ifdef CORE_LSU_LOAD_DATA_REG_EN
  logic [31:0] data_q;

  // Hold the merged result from the final beat until the next load completes.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest)       data_q <= '0;
    else if (finish) data_q <= ext_data;
  end

  assign mem_load_data_valid = (state_q == RESP);
  assign mem_load_data       = data_q;
`else
  assign mem_load_data_valid = finish;
  assign mem_load_data       = finish ? ext_data : 32'b0;
`endif

endmodule

// File: tb/tb_core_ma_lsu_load_merge.sv
// Self-checking bench for core_ma_lsu_load_merge: directed scenarios plus
// randomized loads compared against a byte-level reference model.
module tb_core_ma_lsu_load_merge;
  import core_define::*;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [2:0]  mem_op_type;
  logic [2:0]  mem_op_data_len;
  logic        avl_m0_read;
  logic        avl_m0_request_ready;
  logic [31:0] avl_m0_read_data;
  logic        avl_m0_read_data_valid;
  logic        mem_load_busy;
  logic [31:0] mem_load_data;
  logic        mem_load_data_valid;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  core_ma_lsu_load_merge dut (
    .clk                    (clk),
    .rest                   (rest),
    .mem_addr               (mem_addr),
    .mem_read               (mem_read),
    .mem_op_type            (mem_op_type),
    .mem_op_data_len        (mem_op_data_len),
    .avl_m0_read            (avl_m0_read),
    .avl_m0_request_ready   (avl_m0_request_ready),
    .avl_m0_read_data       (avl_m0_read_data),
    .avl_m0_read_data_valid (avl_m0_read_data_valid),
    .mem_load_busy          (mem_load_busy),
    .mem_load_data          (mem_load_data),
    .mem_load_data_valid    (mem_load_data_valid)
  );

  always @(negedge clk) if (mem_load_data_valid === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed bytes out of the 8-byte window, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] len,
                                           input logic [2:0] typ, input logic [31:0] w0,
                                           input logic [31:0] w1);
    int n;
    int off;
    logic [7:0]  b[8];
    logic [31:0] r;
    n   = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      b[i]   = w0[8*i +: 8];
      b[i+4] = (off + n > 4) ? w1[8*i +: 8] : 8'h00;
    end
    r = 32'b0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = b[off+i];
    if (n < 4 && typ != MEM_OP_TYPE_UNSIGNED && r[8*n-1])
      for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic idle_gap(input string tag, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check({tag, " gap busy"}, 32'(mem_load_busy), 32'd1);
      check({tag, " gap valid"}, 32'(mem_load_data_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // One complete load: command, one or two beats (gap between), result checks.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] len,
                         input logic [2:0] typ, input logic [31:0] w0, input logic [31:0] w1,
                         input int gap, input bit junk, input logic [31:0] exp);
    int n;
    bit two;
    int s0;
    n   = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    two = (int'(addr[1:0]) + n) > 4;
    s0  = strobe_cnt;
    mem_addr = addr; mem_read = 1'b1; mem_op_type = typ; mem_op_data_len = len;
    avl_m0_read = 1'b1; avl_m0_request_ready = 1'b1;
    avl_m0_read_data_valid = junk; avl_m0_read_data = 32'hDEADBEEF;
    @(negedge clk);
    check({tag, " idle busy"}, 32'(mem_load_busy), 32'd0);
    check({tag, " idle valid"}, 32'(mem_load_data_valid), 32'd0);
    @(posedge clk); #1;
    avl_m0_read = two;
    avl_m0_read_data_valid = 1'b0;
    if (!two) idle_gap(tag, gap);
    avl_m0_read_data_valid = 1'b1; avl_m0_read_data = w0;
    if (two) begin
      @(negedge clk);
      check({tag, " beat0 valid"}, 32'(mem_load_data_valid), 32'd0);
      check({tag, " beat0 busy"}, 32'(mem_load_busy), 32'd1);
      @(posedge clk); #1;
      avl_m0_read = 1'b0; avl_m0_read_data_valid = 1'b0;
      idle_gap(tag, gap);
      avl_m0_read_data_valid = 1'b1; avl_m0_read_data = w1;
    end
    @(negedge clk);
`ifdef CORE_LSU_LOAD_DATA_REG_EN
    check({tag, " final-beat valid"}, 32'(mem_load_data_valid), 32'd0);
    @(posedge clk); #1;
    avl_m0_read_data_valid = 1'b0; mem_read = 1'b0; avl_m0_read = 1'b0;
    @(negedge clk);
    check({tag, " resp valid"}, 32'(mem_load_data_valid), 32'd1);
    check({tag, " resp data"}, mem_load_data, exp);
    check({tag, " resp busy"}, 32'(mem_load_busy), 32'd1);
`else
    check({tag, " valid"}, 32'(mem_load_data_valid), 32'd1);
    check({tag, " data"}, mem_load_data, exp);
`endif
    @(posedge clk); #1;
    avl_m0_read_data_valid = 1'b0; mem_read = 1'b0; avl_m0_read = 1'b0;
    @(negedge clk);
    check({tag, " after busy"}, 32'(mem_load_busy), 32'd0);
    check({tag, " after valid"}, 32'(mem_load_data_valid), 32'd0);
`ifdef CORE_LSU_LOAD_DATA_REG_EN
    check({tag, " held data"}, mem_load_data, exp);
`else
    check({tag, " after data"}, mem_load_data, 32'd0);
`endif
    @(posedge clk); #1;
    check({tag, " strobe count"}, 32'(strobe_cnt - s0), 32'd1);
  endtask

  initial begin
    int s0;
    logic [2:0]  len_codes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] ra, rw0, rw1;
    logic [2:0]  rl, rt;

    rest = 1'b0;
    mem_addr = '0; mem_read = 1'b0; mem_op_type = '0; mem_op_data_len = '0;
    avl_m0_read = 1'b0; avl_m0_request_ready = 1'b0;
    avl_m0_read_data = '0; avl_m0_read_data_valid = 1'b0;
    #12;
    check("reset busy", 32'(mem_load_busy), 32'd0);
    check("reset valid", 32'(mem_load_data_valid), 32'd0);
    check("reset data", mem_load_data, 32'd0);
    @(posedge clk); #1;
    rest = 1'b1;

    do_load("lw aligned", 32'h1000, 3'd4, 3'b010, 32'hAABBCCDD, 32'h0, 0, 1'b0, 32'hAABBCCDD);
    do_load("lw split", 32'h1002, 3'd4, 3'b010, 32'hAABBCCDD, 32'h11223344, 0, 1'b0, 32'h3344AABB);
    do_load("lb signed", 32'h2003, 3'd1, 3'b000, 32'h80FFFFFF, 32'h0, 0, 1'b0, 32'hFFFFFF80);
    do_load("lbu", 32'h2003, 3'd1, MEM_OP_TYPE_UNSIGNED, 32'h80FFFFFF, 32'h0, 0, 1'b0, 32'h00000080);
    do_load("lh split gap", 32'h3003, 3'd2, 3'b001, 32'h12000000, 32'h00000034, 3, 1'b0, 32'h00003412);
    do_load("same-cycle beat dropped", 32'h5000, 3'd4, 3'b010, 32'h01234567, 32'h0, 0, 1'b1, 32'h01234567);

    // Reset while waiting for the second beat of a split load.
    s0 = strobe_cnt;
    mem_addr = 32'h1001; mem_op_data_len = 3'd4; mem_op_type = 3'b010; mem_read = 1'b1;
    avl_m0_read = 1'b1; avl_m0_request_ready = 1'b1;
    @(posedge clk); #1;
    avl_m0_read_data_valid = 1'b1; avl_m0_read_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    avl_m0_read_data_valid = 1'b0; avl_m0_read = 1'b0;
    @(negedge clk);
    check("wait1 busy", 32'(mem_load_busy), 32'd1);
    #2 rest = 1'b0;
    #1;
    check("mid-load reset busy", 32'(mem_load_busy), 32'd0);
    check("mid-load reset valid", 32'(mem_load_data_valid), 32'd0);
    check("mid-load reset data", mem_load_data, 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rest = 1'b1;
    @(negedge clk);
    check("post-reset busy", 32'(mem_load_busy), 32'd0);
    @(posedge clk); #1;
    check("post-reset strobes", 32'(strobe_cnt - s0), 32'd0);
    do_load("lw after reset", 32'h4000, 3'd4, 3'b010, 32'h00000005, 32'h0, 0, 1'b0, 32'h00000005);

    // Stray beat while idle produces nothing.
    s0 = strobe_cnt;
    avl_m0_read_data_valid = 1'b1; avl_m0_read_data = 32'hDEADBEEF;
    @(negedge clk);
    check("stray valid", 32'(mem_load_data_valid), 32'd0);
    check("stray busy", 32'(mem_load_busy), 32'd0);
    @(posedge clk); #1;
    avl_m0_read_data_valid = 1'b0;
    @(negedge clk);
    check("stray after busy", 32'(mem_load_busy), 32'd0);
    @(posedge clk); #1;
    check("stray strobes", 32'(strobe_cnt - s0), 32'd0);

    for (int k = 0; k < 40; k++) begin
      ra  = $urandom;
      rl  = len_codes[$urandom_range(0, 5)];
      rt  = ($urandom_range(0, 1) == 1) ? MEM_OP_TYPE_UNSIGNED : 3'($urandom_range(0, 3));
      rw0 = $urandom;
      rw1 = $urandom;
      do_load($sformatf("rand%0d a=%h l=%0d t=%0d", k, ra, rl, rt), ra, rl, rt, rw0, rw1,
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              ref_load(ra, rl, rt, rw0, rw1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
